// File: rtl/yutorina_boot_loader_pkg.sv
// rtl/yutorina_boot_loader_pkg.sv - shared FSM encoding, magic bytes and signal levels for the boot loader
package yutorina_boot_loader_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] MAGIC_0 = 8'h59;
    localparam logic [BYTE_W-1:0] MAGIC_1 = 8'h54;

    localparam logic RESET_ACTIVE  = 1'b1;
    localparam logic ENABLE_ACTIVE = 1'b1;

    typedef enum logic [2:0] {
        ST_HUNT_M0,
        ST_HUNT_M1,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } boot_state_e;

endpackage

// File: rtl/yutorina_boot_loader_if.sv
// rtl/yutorina_boot_loader_if.sv - byte stream in and SPM write port out of the boot loader
interface yutorina_boot_loader_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] spm_addr;
    logic [DATA_W-1:0] spm_wr_data;
    logic              spm_we;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, spm_addr, spm_wr_data, spm_we
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, spm_addr, spm_wr_data, spm_we
    );
endinterface

// File: rtl/yutorina_boot_timeout.sv
// rtl/yutorina_boot_timeout.sv - idle-cycle watchdog between bytes of a started frame
module yutorina_boot_timeout
    import yutorina_boot_loader_pkg::*;
#(
    parameter int TIMEOUT = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] count;

            always_ff @(posedge clock or posedge reset) begin
                if (reset == RESET_ACTIVE) begin
                    count <= '0;
                end else if (clear || (enable != ENABLE_ACTIVE)) begin
                    count <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end

            // Fires during the TIMEOUT-th consecutive idle cycle so the FSM leaves at its end.
            assign expired = (enable == ENABLE_ACTIVE) && !clear && (count == CW'(TIMEOUT - 1));
        end
    endgenerate
endmodule

// File: rtl/yutorina_boot_loader.sv
// rtl/yutorina_boot_loader.sv - loads a framed image into SPM and releases the CPU
// YUTORINA_BOOT_CHECKSUM_EN adds a trailing checksum byte that must match the data byte sum.
module yutorina_boot_loader
    import yutorina_boot_loader_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int BASE_ADDR = 0,
    parameter int TIMEOUT   = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    yutorina_boot_loader_if.slave bus,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);
    localparam int     BPW     = DATA_W / BYTE_W;
    localparam int     BC_W    = (BPW > 1) ? $clog2(BPW) : 1;
    localparam longint MAX_LEN = (longint'(1) << ADDR_W) - longint'(BASE_ADDR);
`ifdef YUTORINA_BOOT_CHECKSUM_EN
    localparam boot_state_e ST_AFTER_DATA = ST_CHECK;
`else
    localparam boot_state_e ST_AFTER_DATA = ST_DONE;
`endif

    boot_state_e       state, state_n;
    logic [7:0]        len_hi;
    logic [15:0]       words_left;
    logic [15:0]       len_word;
    logic [BC_W-1:0]   byte_cnt;
    logic [DATA_W-1:0] shift, shift_n;
    logic              rx_ready_q, spm_we_q, cpu_reset_q, done_q, error_q;
    logic [ADDR_W-1:0] spm_addr_q;
    logic [DATA_W-1:0] spm_wr_data_q;
    logic              accept, word_last, word_done, expired, timer_en;
`ifdef YUTORINA_BOOT_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign accept    = bus.rx_valid & rx_ready_q;
    assign len_word  = {len_hi, bus.rx_data};
    assign word_last = (byte_cnt == BC_W'(BPW - 1));
    assign shift_n   = (shift << BYTE_W) | DATA_W'(bus.rx_data);
    assign timer_en  = (state inside {ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHECK});

    yutorina_boot_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (accept),
        .enable  (timer_en),
        .expired (expired)
    );

    always_comb begin
        state_n   = state;
        word_done = 1'b0;
        case (state)
            ST_HUNT_M0: if (accept && bus.rx_data == MAGIC_0) state_n = ST_HUNT_M1;
            ST_HUNT_M1: if (accept) begin
                if (bus.rx_data == MAGIC_1)      state_n = ST_LEN_HI;
                else if (bus.rx_data != MAGIC_0) state_n = ST_HUNT_M0;
            end
            ST_LEN_HI: begin
                if (accept)       state_n = ST_LEN_LO;
                else if (expired) state_n = ST_ERROR;
            end
            ST_LEN_LO: begin
                if (accept) begin
                    if (longint'(len_word) > MAX_LEN) state_n = ST_ERROR;
                    else if (len_word == 16'd0)       state_n = ST_AFTER_DATA;
                    else                              state_n = ST_DATA;
                end else if (expired) begin
                    state_n = ST_ERROR;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    if (word_last) begin
                        word_done = 1'b1;
                        if (words_left == 16'd1) state_n = ST_AFTER_DATA;
                    end
                end else if (expired) begin
                    state_n = ST_ERROR;
                end
            end
`ifdef YUTORINA_BOOT_CHECKSUM_EN
            ST_CHECK: begin
                if (accept)       state_n = (bus.rx_data == csum) ? ST_DONE : ST_ERROR;
                else if (expired) state_n = ST_ERROR;
            end
`endif
            // Bytes accepted during the single ERROR cycle are dropped.
            ST_ERROR: state_n = ST_HUNT_M0;
            default:  state_n = state;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset == RESET_ACTIVE) begin
            state         <= ST_HUNT_M0;
            len_hi        <= '0;
            words_left    <= '0;
            byte_cnt      <= '0;
            shift         <= '0;
            rx_ready_q    <= 1'b0;
            spm_we_q      <= 1'b0;
            spm_addr_q    <= ADDR_W'(BASE_ADDR);
            spm_wr_data_q <= '0;
            cpu_reset_q   <= 1'b1;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state      <= state_n;
            rx_ready_q <= (state_n != ST_DONE);
            spm_we_q   <= word_done;
            if (state == ST_ERROR)  spm_addr_q <= ADDR_W'(BASE_ADDR);
            else if (spm_we_q)      spm_addr_q <= spm_addr_q + 1'b1;
            if (accept && state == ST_LEN_HI) len_hi <= bus.rx_data;
            if (accept && state == ST_LEN_LO) begin
                words_left <= len_word;
                byte_cnt   <= '0;
            end
            if (accept && state == ST_DATA) begin
                shift    <= shift_n;
                byte_cnt <= word_last ? '0 : byte_cnt + 1'b1;
                if (word_last) begin
                    spm_wr_data_q <= shift_n;
                    words_left    <= words_left - 16'd1;
                end
            end
            if (state_n == ST_DONE && state != ST_DONE) begin
                cpu_reset_q <= 1'b0;
                done_q      <= 1'b1;
            end
            if (state_n == ST_ERROR) error_q <= 1'b1;
        end
    end

`ifdef YUTORINA_BOOT_CHECKSUM_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset == RESET_ACTIVE)             csum <= '0;
        else if (state == ST_ERROR)            csum <= '0;
        else if (accept && state == ST_DATA)   csum <= csum + bus.rx_data;
    end
`endif

    assign bus.rx_ready    = rx_ready_q;
    assign bus.spm_we      = spm_we_q;
    assign bus.spm_addr    = spm_addr_q;
    assign bus.spm_wr_data = spm_wr_data_q;
    assign cpu_reset       = cpu_reset_q;
    assign done            = done_q;
    assign error           = error_q;
endmodule
